// File: rtl/bt656_pkg.sv
// Shared constants, TRS state encoding and XY protection helper for the BT.656 receiver.
package bt656_pkg;

  localparam logic [7:0] PRE_FF = 8'hFF;
  localparam logic [7:0] PRE_00 = 8'h00;

  localparam int XY_ONE = 7;
  localparam int XY_F   = 6;
  localparam int XY_V   = 5;
  localparam int XY_H   = 4;

  typedef enum logic [2:0] {
    BLANK  = 3'd0,
    ACTIVE = 3'd1,
    P_FF   = 3'd2,
    P_00   = 3'd3,
    P_0000 = 3'd4
  } trs_state_t;

  function automatic logic [3:0] xy_prot(input logic f, input logic v, input logic h);
    return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

endpackage

// File: rtl/bt656_trs_detect.sv
// Preamble tracker and XY decoder: flags valid/invalid codes, aborted preambles,
// and whether the current preamble interrupted an active line.
module bt656_trs_detect
  import bt656_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] bt_data,
  output logic       video_byte,
  output logic       code_valid,
  output logic       code_err,
  output logic       abort,
  output logic       line_open,
  output logic       f,
  output logic       v,
  output logic       h
);

  trs_state_t state_reg, state_next;
  logic       line_open_reg, line_open_next;
  logic       xy_ok;

  assign xy_ok = bt_data[XY_ONE] &&
                 (bt_data[3:0] == xy_prot(bt_data[XY_F], bt_data[XY_V], bt_data[XY_H]));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= BLANK;
      line_open_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      line_open_reg <= line_open_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    line_open_next = line_open_reg;
    case (state_reg)
      BLANK, ACTIVE: begin
        if (bt_data == PRE_FF) begin
          state_next     = P_FF;
          line_open_next = (state_reg == ACTIVE);
        end
      end
      P_FF: begin
        if (bt_data == PRE_00)      state_next = P_00;
        else if (bt_data != PRE_FF) state_next = BLANK;
      end
      P_00: begin
        if (bt_data == PRE_00)      state_next = P_0000;
        else if (bt_data == PRE_FF) state_next = P_FF;
        else                        state_next = BLANK;
      end
      P_0000: begin
        // Only a clean SAV for an active line re-enters ACTIVE.
        if (xy_ok && !bt_data[XY_H] && !bt_data[XY_V]) state_next = ACTIVE;
        else                                            state_next = BLANK;
      end
      default: state_next = BLANK;
    endcase
  end

  always_comb begin
    video_byte = (state_reg == ACTIVE) && (bt_data != PRE_FF);
    code_valid = (state_reg == P_0000) && xy_ok;
    code_err   = (state_reg == P_0000) && !xy_ok;
    abort      = ((state_reg == P_FF) || (state_reg == P_00)) &&
                 (bt_data != PRE_00) && (bt_data != PRE_FF);
    line_open  = line_open_reg;
    f          = bt_data[XY_F];
    v          = bt_data[XY_V];
    h          = bt_data[XY_H];
  end

endmodule

// File: rtl/bt656_decoder.sv
// BT.656 receiver: turns the 4:2:2 byte stream into {C,Y} Avalon-ST pixels framed per field,
// with lock tracking and saturating error accounting.
module bt656_decoder
  import bt656_pkg::*;
#(
  parameter int ACTIVE_PIXELS = 720,
  parameter int ACTIVE_LINES  = 288,
  parameter int LOCK_COUNT    = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  bt_data,
  output logic [15:0] av_data,
  output logic        av_valid,
  output logic        av_sop,
  output logic        av_eop,
  output logic        field,
  output logic        vblank,
  output logic        locked,
  output logic        prot_err,
  output logic        sync_err,
  output logic        len_err,
  output logic [15:0] err_count
);

  localparam int PW = $clog2(2 * ACTIVE_PIXELS + 2);
  localparam int LW = $clog2(ACTIVE_LINES + 2);
  localparam int KW = $clog2(LOCK_COUNT + 1);

  localparam logic [PW-1:0] LINE_BYTES = PW'(2 * ACTIVE_PIXELS);
  localparam logic [PW-1:0] BYTE_SAT   = PW'(2 * ACTIVE_PIXELS + 1);
  localparam logic [PW-2:0] NUM_PIX    = (PW-1)'(ACTIVE_PIXELS);
  localparam logic [PW-2:0] LAST_PIX   = (PW-1)'(ACTIVE_PIXELS - 1);
  localparam logic [LW-1:0] NUM_LINES  = LW'(ACTIVE_LINES);
  localparam logic [LW-1:0] LAST_LINE  = LW'(ACTIVE_LINES - 1);
  localparam logic [LW-1:0] LINE_SAT   = LW'(ACTIVE_LINES + 1);
  localparam logic [KW-1:0] LOCK_MAX   = KW'(LOCK_COUNT);

  logic video_byte, code_valid, code_err, abort, line_open, xy_f, xy_v, xy_h;

  bt656_trs_detect u_trs (
    .clock      (clock),
    .reset_n    (reset_n),
    .bt_data    (bt_data),
    .video_byte (video_byte),
    .code_valid (code_valid),
    .code_err   (code_err),
    .abort      (abort),
    .line_open  (line_open),
    .f          (xy_f),
    .v          (xy_v),
    .h          (xy_h)
  );

  logic          field_reg, field_next, vblank_reg, vblank_next;
  logic [KW-1:0] lock_cnt_reg, lock_cnt_next;
  logic          locked_reg, locked_next;
  logic          line_emit_reg, line_emit_next;
  logic [PW-1:0] byte_cnt_reg, byte_cnt_next;
  logic [7:0]    chroma_reg, chroma_next;
  logic [LW-1:0] line_cnt_reg, line_cnt_next, line_inc;
  logic [15:0]   av_data_reg, av_data_next;
  logic          av_valid_reg, av_valid_next, av_sop_reg, av_sop_next, av_eop_reg, av_eop_next;
  logic          prot_err_reg, prot_err_next, sync_err_reg, sync_err_next, len_err_reg, len_err_next;
  logic [15:0]   err_count_reg, err_count_next;
  logic [16:0]   err_sum;

  logic          sav, eav, v_edge, line_full, line_short, sync_hit;
  logic [PW-2:0] pix;

  assign sav        = code_valid && !xy_h;
  assign eav        = code_valid && xy_h;
  assign v_edge     = code_valid && xy_v && !vblank_reg;
  assign line_full  = eav && line_open && (byte_cnt_reg == LINE_BYTES);
  assign line_short = eav && line_open && (byte_cnt_reg != LINE_BYTES);
  assign sync_hit   = abort && line_open;
  assign pix        = byte_cnt_reg[PW-1:1];

  // Only full-length lines advance the line index, so a short line also suppresses EOP.
  assign line_inc = (line_full && line_cnt_reg != LINE_SAT) ? line_cnt_reg + LW'(1) : line_cnt_reg;

  always_comb begin
    field_next     = field_reg;
    vblank_next    = vblank_reg;
    lock_cnt_next  = lock_cnt_reg;
    line_emit_next = line_emit_reg;
    byte_cnt_next  = byte_cnt_reg;
    chroma_next    = chroma_reg;
    line_cnt_next  = line_inc;
    av_data_next   = av_data_reg;
    av_valid_next  = 1'b0;
    av_sop_next    = 1'b0;
    av_eop_next    = 1'b0;
    prot_err_next  = code_err;
    sync_err_next  = sync_hit;
    len_err_next   = line_short;

    if (code_valid) begin
      field_next  = xy_f;
      vblank_next = xy_v;
    end

    if (code_err || sync_hit)
      lock_cnt_next = '0;
    else if (code_valid && lock_cnt_reg != LOCK_MAX)
      lock_cnt_next = lock_cnt_reg + KW'(1);
    locked_next = (lock_cnt_next == LOCK_MAX);

    if (v_edge) begin
      line_cnt_next = '0;
      if (line_inc != '0 && line_inc != NUM_LINES) len_err_next = 1'b1;
    end

    if (sav) begin
      byte_cnt_next  = '0;
      line_emit_next = !xy_v && locked_next;
    end else if (video_byte) begin
      if (byte_cnt_reg != BYTE_SAT) byte_cnt_next = byte_cnt_reg + PW'(1);
      if (!byte_cnt_reg[0]) begin
        chroma_next = bt_data;
      end else if (line_emit_reg && pix < NUM_PIX) begin
        av_valid_next = 1'b1;
        av_data_next  = {chroma_reg, bt_data};
        av_sop_next   = (pix == '0) && (line_cnt_reg == '0);
        av_eop_next   = (pix == LAST_PIX) && (line_cnt_reg == LAST_LINE);
      end
    end

    err_sum = {1'b0, err_count_reg} + 17'(prot_err_next) + 17'(sync_err_next) + 17'(len_err_next);
    err_count_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      field_reg     <= 1'b0;
      vblank_reg    <= 1'b0;
      lock_cnt_reg  <= '0;
      locked_reg    <= 1'b0;
      line_emit_reg <= 1'b0;
      byte_cnt_reg  <= '0;
      chroma_reg    <= '0;
      line_cnt_reg  <= '0;
      av_data_reg   <= '0;
      av_valid_reg  <= 1'b0;
      av_sop_reg    <= 1'b0;
      av_eop_reg    <= 1'b0;
      prot_err_reg  <= 1'b0;
      sync_err_reg  <= 1'b0;
      len_err_reg   <= 1'b0;
      err_count_reg <= '0;
    end else begin
      field_reg     <= field_next;
      vblank_reg    <= vblank_next;
      lock_cnt_reg  <= lock_cnt_next;
      locked_reg    <= locked_next;
      line_emit_reg <= line_emit_next;
      byte_cnt_reg  <= byte_cnt_next;
      chroma_reg    <= chroma_next;
      line_cnt_reg  <= line_cnt_next;
      av_data_reg   <= av_data_next;
      av_valid_reg  <= av_valid_next;
      av_sop_reg    <= av_sop_next;
      av_eop_reg    <= av_eop_next;
      prot_err_reg  <= prot_err_next;
      sync_err_reg  <= sync_err_next;
      len_err_reg   <= len_err_next;
      err_count_reg <= err_count_next;
    end
  end

  assign av_data   = av_data_reg;
  assign av_valid  = av_valid_reg;
  assign av_sop    = av_sop_reg;
  assign av_eop    = av_eop_reg;
  assign field     = field_reg;
  assign vblank    = vblank_reg;
  assign locked    = locked_reg;
  assign prot_err  = prot_err_reg;
  assign sync_err  = sync_err_reg;
  assign len_err   = len_err_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_bt656_decoder.sv
// Line-level stimulus with a field/line/lock model; expected pixels are queued and matched in order.
module tb_bt656_decoder;

  localparam int AP = 8;
  localparam int AL = 4;
  localparam int LC = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  bt_data = 8'h00;
  logic [15:0] av_data;
  logic        av_valid, av_sop, av_eop, field, vblank, locked;
  logic        prot_err, sync_err, len_err;
  logic [15:0] err_count;

  bt656_decoder #(.ACTIVE_PIXELS(AP), .ACTIVE_LINES(AL), .LOCK_COUNT(LC)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bt_data   (bt_data),
    .av_data   (av_data),
    .av_valid  (av_valid),
    .av_sop    (av_sop),
    .av_eop    (av_eop),
    .field     (field),
    .vblank    (vblank),
    .locked    (locked),
    .prot_err  (prot_err),
    .sync_err  (sync_err),
    .len_err   (len_err),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int lock_cnt = 0, line_idx = 0;
  bit vb = 1'b0;
  int exp_prot = 0, exp_sync = 0, exp_len = 0;
  int obs_prot = 0, obs_sync = 0, obs_len = 0, obs_sop = 0, obs_eop = 0;
  logic [17:0] exp_q[$];

  function automatic logic [7:0] xy(input bit f, input bit v, input bit h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  function automatic logic [7:0] rnd_byte();
    return 8'($urandom_range(1, 254));
  endfunction

  // Drive one byte, then look at the registered result of that byte.
  task automatic send_byte(input logic [7:0] b);
    logic [17:0] want;
    bt_data = b;
    @(posedge clock);
    #1;
    if (prot_err) obs_prot++;
    if (sync_err) obs_sync++;
    if (len_err) obs_len++;
    if (av_valid) begin
      if (av_sop) obs_sop++;
      if (av_eop) obs_eop++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pixel_unexpected got data=%h sop=%b eop=%b required no pixel", av_data, av_sop, av_eop);
      end else begin
        want = exp_q.pop_front();
        if ({av_sop, av_eop, av_data} !== want) begin
          bad++;
          $display("FAIL pixel got sop=%b eop=%b data=%h required sop=%b eop=%b data=%h",
                   av_sop, av_eop, av_data, want[17], want[16], want[15:0]);
        end
      end
    end
  endtask

  task automatic send_code(input logic [7:0] c);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(c);
  endtask

  task automatic blank_bytes(input int n);
    for (int i = 0; i < n; i++) send_byte((i % 2 == 0) ? 8'h80 : 8'h10);
  endtask

  // Well-formed code plus the model's lock and field-length bookkeeping.
  task automatic code_ok(input bit f, input bit v, input bit h);
    send_code(xy(f, v, h));
    if (lock_cnt < LC) lock_cnt++;
    if (v && !vb) begin
      if (line_idx != 0 && line_idx != AL) exp_len++;
      line_idx = 0;
    end
    vb = v;
  endtask

  task automatic send_pixels(input bit emit, input int n);
    logic [7:0] c, y;
    for (int i = 0; i < n; i++) begin
      c = rnd_byte();
      y = rnd_byte();
      if (emit && i < AP)
        exp_q.push_back({(i == 0 && line_idx == 0), (i == AP - 1 && line_idx == AL - 1), c, y});
      send_byte(c);
      send_byte(y);
    end
  endtask

  task automatic active_line(input bit f, input int npix);
    bit emit;
    code_ok(f, 1'b0, 1'b0);
    emit = (lock_cnt == LC);
    send_pixels(emit, npix);
    code_ok(f, 1'b0, 1'b1);
    if (npix != AP) exp_len++;
    else line_idx++;
    blank_bytes(4);
  endtask

  task automatic blank_line(input bit f);
    code_ok(f, 1'b1, 1'b0);
    blank_bytes(8);
    code_ok(f, 1'b1, 1'b1);
    blank_bytes(4);
  endtask

  task automatic check_errs(input string tag);
    total++;
    if (err_count !== 16'(exp_prot + exp_sync + exp_len)) begin
      bad++;
      $display("FAIL %s_err_count got=%0d required=%0d", tag, err_count, exp_prot + exp_sync + exp_len);
    end
    total++;
    if (obs_prot != exp_prot || obs_sync != exp_sync || obs_len != exp_len) begin
      bad++;
      $display("FAIL %s_pulses got prot=%0d sync=%0d len=%0d required prot=%0d sync=%0d len=%0d",
               tag, obs_prot, obs_sync, obs_len, exp_prot, exp_sync, exp_len);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if ({av_valid, av_sop, av_eop, av_data, field, vblank, locked, prot_err, sync_err, len_err, err_count} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got valid=%b data=%h locked=%b err=%0d required all zero",
               av_valid, av_data, locked, err_count);
    end
    reset_n = 1'b1;
    send_byte(8'h10);
    total++;
    if ({av_valid, locked, field, vblank, err_count} !== '0) begin
      bad++;
      $display("FAIL reset_release got valid=%b locked=%b field=%b vblank=%b err=%0d required zero",
               av_valid, locked, field, vblank, err_count);
    end
  endtask

  task automatic test_lock;
    for (int k = 1; k <= LC; k++) begin
      code_ok(1'b0, 1'b1, (k % 2) == 0);
      total++;
      if (locked !== (k >= LC)) begin
        bad++;
        $display("FAIL lock_after_code%0d got=%b required=%b", k, locked, k >= LC);
      end
      blank_bytes(4);
    end
    total++;
    if (field !== 1'b0 || vblank !== 1'b1) begin
      bad++;
      $display("FAIL lock_fv got field=%b vblank=%b required field=0 vblank=1", field, vblank);
    end
  endtask

  task automatic test_full_field;
    int sop0, eop0;
    sop0 = obs_sop;
    eop0 = obs_eop;
    for (int l = 0; l < AL; l++) active_line(1'b0, AP);
    blank_line(1'b0);
    blank_line(1'b0);
    total++;
    if (obs_sop - sop0 != 1 || obs_eop - eop0 != 1) begin
      bad++;
      $display("FAIL field0_framing got sop=%0d eop=%0d required sop=1 eop=1", obs_sop - sop0, obs_eop - eop0);
    end
    check_errs("field0");
  endtask

  task automatic test_field1;
    int sop0;
    sop0 = obs_sop;
    active_line(1'b1, AP);
    total++;
    if (field !== 1'b1 || vblank !== 1'b0 || obs_sop - sop0 != 1) begin
      bad++;
      $display("FAIL field1_start got field=%b vblank=%b sop=%0d required field=1 vblank=0 sop=1",
               field, vblank, obs_sop - sop0);
    end
    for (int l = 1; l < AL; l++) active_line(1'b1, AP);
    blank_line(1'b1);
    check_errs("field1");
  endtask

  task automatic test_prot_err;
    active_line(1'b0, AP);
    code_ok(1'b0, 1'b0, 1'b0);
    send_pixels(lock_cnt == LC, AP);
    send_code(8'h9C);
    lock_cnt = 0;
    exp_prot++;
    total++;
    if (locked !== 1'b0) begin
      bad++;
      $display("FAIL prot_unlock got=%b required=0", locked);
    end
    check_errs("prot");
    blank_bytes(4);
    active_line(1'b0, AP);
    total++;
    if (locked !== 1'b0) begin
      bad++;
      $display("FAIL prot_still_unlocked got=%b required=0", locked);
    end
    active_line(1'b0, AP);
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL prot_relock got=%b required=1", locked);
    end
    blank_line(1'b0);
    check_errs("prot_field");
  endtask

  task automatic test_short_line;
    int eop0;
    eop0 = obs_eop;
    active_line(1'b0, AP);
    active_line(1'b0, AP - 2);
    total++;
    if (obs_len != exp_len) begin
      bad++;
      $display("FAIL short_len_pulse got=%0d required=%0d", obs_len, exp_len);
    end
    active_line(1'b0, AP);
    active_line(1'b0, AP);
    blank_line(1'b0);
    total++;
    if (obs_eop != eop0) begin
      bad++;
      $display("FAIL short_no_eop got=%0d required=0", obs_eop - eop0);
    end
    check_errs("short");
  endtask

  task automatic test_sync_err;
    active_line(1'b0, AP);
    code_ok(1'b0, 1'b0, 1'b0);
    send_pixels(lock_cnt == LC, 3);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'h55);
    lock_cnt = 0;
    exp_sync++;
    total++;
    if (locked !== 1'b0 || obs_sync != exp_sync) begin
      bad++;
      $display("FAIL sync_abort got locked=%b sync=%0d required locked=0 sync=%0d", locked, obs_sync, exp_sync);
    end
    for (int i = 0; i < 2 * AP - 9; i++) send_byte(rnd_byte());
    code_ok(1'b0, 1'b0, 1'b1);
    blank_bytes(4);
    active_line(1'b0, AP);
    active_line(1'b0, AP);
    blank_line(1'b0);
    check_errs("sync");
  endtask

  task automatic test_reset_mid;
    code_ok(1'b0, 1'b0, 1'b0);
    send_pixels(lock_cnt == LC, 4);
    total++;
    if (av_valid !== 1'b1) begin
      bad++;
      $display("FAIL midreset_pre_valid got=%b required=1", av_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({av_valid, av_sop, av_eop, av_data, field, vblank, locked, prot_err, sync_err, len_err, err_count} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs got valid=%b data=%h locked=%b err=%0d required all zero",
               av_valid, av_data, locked, err_count);
    end
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    lock_cnt = 0; line_idx = 0; vb = 1'b0;
    exp_prot = 0; exp_sync = 0; exp_len = 0;
    obs_prot = 0; obs_sync = 0; obs_len = 0;
    active_line(1'b0, AP);
    active_line(1'b0, AP);
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL midreset_relock got=%b required=1", locked);
    end
    active_line(1'b0, AP);
    check_errs("midreset");
  endtask

  initial begin
    test_reset;
    test_lock;
    test_full_field;
    test_field1;
    test_prot_err;
    test_short_line;
    test_sync_err;
    test_reset_mid;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pixels_missing got=0 required=%0d more pixels", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
